// File: rtl/cr16_pkg.sv
// Shared CR16 encodings: opcodes, extension codes, FSM states, condition codes
// and the select encodings used by the register-file write mux and PC mux.
package cr16_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_RD = 3'd3
  } state_t;

  localparam logic [3:0] OPC_RTYPE = 4'h0;
  localparam logic [3:0] OPC_ANDI  = 4'h1;
  localparam logic [3:0] OPC_ORI   = 4'h2;
  localparam logic [3:0] OPC_XORI  = 4'h3;
  localparam logic [3:0] OPC_MEM   = 4'h4;
  localparam logic [3:0] OPC_ADDI  = 4'h5;
  localparam logic [3:0] OPC_ADDUI = 4'h6;
  localparam logic [3:0] OPC_SHIFT = 4'h8;
  localparam logic [3:0] OPC_SUBI  = 4'h9;
  localparam logic [3:0] OPC_CMPI  = 4'hB;
  localparam logic [3:0] OPC_BCOND = 4'hC;
  localparam logic [3:0] OPC_MOVI  = 4'hD;
  localparam logic [3:0] OPC_LUI   = 4'hF;

  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC  = 2'd2;

  localparam logic [1:0] PCSRC_INC = 2'd0;
  localparam logic [1:0] PCSRC_REL = 2'd1;
  localparam logic [1:0] PCSRC_REG = 2'd2;

  // PSR bit positions within {N,Z,F,L,C}
  localparam int PSR_N = 4;
  localparam int PSR_Z = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;
  localparam int PSR_C = 0;

endpackage

// File: rtl/cr16_control_fsm_cond_eval.sv
// Branch/jump condition evaluator: decides whether a Bcond/Jcond is taken
// from the 4-bit condition field and the current PSR.
module cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [4:0] i_psr,
  output logic       o_take
);

  always_comb begin
    o_take = 1'b0;
    case (i_cond)
      CC_EQ: o_take = i_psr[PSR_Z];
      CC_NE: o_take = !i_psr[PSR_Z];
      CC_CS: o_take = i_psr[PSR_C];
      CC_CC: o_take = !i_psr[PSR_C];
      CC_HI: o_take = i_psr[PSR_L];
      CC_LS: o_take = !i_psr[PSR_L];
      CC_GT: o_take = i_psr[PSR_N];
      CC_LE: o_take = !i_psr[PSR_N];
      CC_FS: o_take = i_psr[PSR_F];
      CC_FC: o_take = !i_psr[PSR_F];
      CC_LO: o_take = !i_psr[PSR_L] && !i_psr[PSR_Z];
      CC_HS: o_take = i_psr[PSR_L] || i_psr[PSR_Z];
      CC_LT: o_take = !i_psr[PSR_N] && !i_psr[PSR_Z];
      CC_GE: o_take = i_psr[PSR_N] || i_psr[PSR_Z];
      CC_UC: o_take = 1'b1;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multicycle CR16 controller: fetches into IR, decodes ALU/memory/branch
// control, and keeps the PSR updated from the ALU condition outputs.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        alu_cond_group1,
  input  logic [2:0]        alu_cond_group2,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm_out,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  output logic [3:0]        rf_waddr,
  output logic              rf_we,
  output logic [1:0]        rf_wsel,
  output logic              mem_addr_sel,
  output logic              mem_we,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic [4:0]        psr_out,
  output logic [2:0]        state_out
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_ir;
  logic [4:0]        r_psr;
  logic [3:0]        w_opc;
  logic [3:0]        w_ext;
  logic              w_is_alu;
  logic              w_is_cmp;
  logic              w_sets_psr;
  logic              w_src_imm;
  logic              w_take;
  logic              w_ir_load;
  logic              w_psr_we;
  logic [4:0]        w_psr_new;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_psr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_load) r_ir <= mem_rdata;
      if (w_psr_we)  r_psr <= w_psr_new;
    end
  end

  assign w_opc      = r_ir[15:12];
  assign w_ext      = r_ir[7:4];
  assign w_psr_new  = {alu_cond_group2[2], alu_cond_group2[1], alu_cond_group1[1],
                       alu_cond_group2[0], alu_cond_group1[0]};
  assign w_is_alu   = w_opc inside {OPC_RTYPE, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_ADDI,
                                    OPC_ADDUI, OPC_SHIFT, OPC_SUBI, OPC_CMPI, OPC_MOVI, OPC_LUI};
  assign w_is_cmp   = (w_opc == OPC_CMPI) || (w_opc == OPC_RTYPE && w_ext == EXT_CMP);
  assign w_sets_psr = (w_opc inside {OPC_ADDI, OPC_SUBI, OPC_CMPI}) ||
                      (w_opc == OPC_RTYPE && w_ext inside {EXT_ADD, EXT_SUB, EXT_CMP});
  // Shift class: only extensions 00xx are the immediate-count forms
  assign w_src_imm  = !(w_opc == OPC_RTYPE || (w_opc == OPC_SHIFT && w_ext[3:2] != 2'b00));

  assign rf_raddr_a = r_ir[11:8];
  assign rf_raddr_b = r_ir[3:0];
  assign rf_waddr   = r_ir[11:8];
  assign psr_out    = r_psr;
  assign state_out  = r_state;

  always_comb begin
    if (w_opc inside {OPC_ADDI, OPC_SUBI, OPC_CMPI, OPC_BCOND}) begin
      imm_out = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    end else if (w_opc == OPC_SHIFT) begin
      imm_out = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
    end else begin
      imm_out = {{(DATA_W-8){1'b0}}, r_ir[7:0]};
    end
  end

  cond_eval u_cond_eval (
    .i_cond (r_ir[11:8]),
    .i_psr  (r_psr),
    .o_take (w_take)
  );

  always_comb begin
    w_next       = r_state;
    alu_op       = '0;
    alu_src_imm  = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = WSEL_ALU;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    pc_en        = 1'b0;
    pc_src       = PCSRC_INC;
    w_psr_we     = 1'b0;
    w_ir_load    = 1'b0;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        w_ir_load = 1'b1;
        w_next    = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        pc_en  = 1'b1;
        if (w_is_alu) begin
          alu_op      = (w_opc == OPC_RTYPE || w_opc == OPC_SHIFT) ? {w_opc, w_ext} : {w_opc, 4'b0000};
          alu_src_imm = w_src_imm;
          rf_we       = !w_is_cmp;
          w_psr_we    = w_sets_psr;
        end else if (w_opc == OPC_MEM && w_ext == EXT_LOAD) begin
          mem_addr_sel = 1'b1;
          pc_en        = 1'b0;
          w_next       = ST_MEM_RD;
        end else if (w_opc == OPC_MEM && w_ext == EXT_STOR) begin
          mem_addr_sel = 1'b1;
          mem_we       = 1'b1;
        end else if (w_opc == OPC_MEM && w_ext == EXT_JAL) begin
          rf_we   = 1'b1;
          rf_wsel = WSEL_PC;
          pc_src  = PCSRC_REG;
        end else if (w_opc == OPC_MEM && w_ext == EXT_JCOND) begin
          pc_src = w_take ? PCSRC_REG : PCSRC_INC;
        end else if (w_opc == OPC_BCOND) begin
          pc_src = w_take ? PCSRC_REL : PCSRC_INC;
        end
      end
      ST_MEM_RD: begin
        rf_we   = 1'b1;
        rf_wsel = WSEL_MEM;
        pc_en   = 1'b1;
        w_next  = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
    // An asserted reset aborts the current instruction before any write lands
    if (!reset_n) begin
      rf_we     = 1'b0;
      mem_we    = 1'b0;
      pc_en     = 1'b0;
      w_psr_we  = 1'b0;
      w_ir_load = 1'b0;
    end
  end

endmodule

// File: doc/cr16_control_fsm.md
Name: cr16_control_fsm

Overview:
- Multicycle controller directly upstream of the ALU.
- Fetches and holds the instruction and decodes it into alu_op, operand/immediate selects and register-file/memory/PC enables.
- Holds the processor status register (PSR), fed back from the ALU condition outputs.
- Evaluates Bcond/Jcond conditions against the PSR.

Parameters:
- DATA_W, 16, datapath and instruction width.
- OP_W, 8, ALU opcode width ({inst[15:12], inst[7:4]}).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- mem_rdata  in  16  instruction/data read from memory (synchronous read, valid the cycle after the address).
- alu_cond_group1  in  2  {F,C} from ALU.
- alu_cond_group2  in  3  {N,Z,L} from ALU.
- alu_op  out  8  ALU opcode.
- alu_src_imm  out  1  1 = ALU in2 is imm_out, 0 = Rsrc.
- imm_out  out  16  extended immediate.
- rf_raddr_a  out  4  inst[11:8] (Rdest).
- rf_raddr_b  out  4  inst[3:0] (Rsrc/Raddr/Rtarget).
- rf_waddr  out  4  inst[11:8].
- rf_we  out  1  register-file write enable.
- rf_wsel  out  2  0 = ALU, 1 = mem_rdata, 2 = PC+1.
- mem_addr_sel  out  1  0 = PC, 1 = Rsrc.
- mem_we  out  1  memory write (data = Rdest).
- pc_en  out  1  PC update strobe.
- pc_src  out  2  0 = PC+1, 1 = PC+imm_out, 2 = Rsrc.
- psr_out  out  5  {N,Z,F,L,C}.
- state_out  out  3  current state (debug).

Behaviour:
- Reset (reset_n low at clk edge):
  - State = FETCH; IR = 16'h0000; PSR = 0.
  - All enables (rf_we, mem_we, pc_en, psr write) = 0; alu_op = 8'h00.
  - Reset mid-instruction aborts it with no writes.
- States: FETCH -> DECODE -> EXEC -> (MEM_RD) -> FETCH.
- FETCH: mem_addr_sel = 0. No enables asserted.
- DECODE: IR <= mem_rdata. No enables asserted.
- EXEC, decoded from IR:
  - ALU register/immediate ops (opcodes 0000, 0001–0011, 0101, 0110, 1000, 1001, 1011, 1101, 1111):
    - alu_op = {IR[15:12], IR[7:4]} for the 0000 and 1000 classes, otherwise {IR[15:12], 4'b0000}.
    - rf_we = 1 except CMP/CMPI.
    - PSR <= ALU conditions at end of EXEC, only for ADD/ADDI/SUB/SUBI/CMP/CMPI.
    - pc_en = 1, pc_src = 0.
    - Total 3 cycles.
  - LOAD (0100 0000): mem_addr_sel = 1, then go to MEM_RD.
  - MEM_RD: rf_we = 1, rf_wsel = 1, pc_en = 1. Total 4 cycles.
  - STOR (0100 0100): mem_addr_sel = 1, mem_we = 1, pc_en = 1. 3 cycles.
  - JAL (0100 1000): rf_we = 1, rf_wsel = 2, pc_en = 1, pc_src = 2.
  - Jcond (0100 1100): cond = IR[11:8]; if true pc_src = 2, else 0; pc_en = 1.
  - Bcond (1100): cond = IR[11:8]; if true pc_src = 1, else 0; pc_en = 1.
  - Any other encoding: NOP (pc_en = 1, pc_src = 0, no writes).
- Immediate extension:
  - Sign-extend IR[7:0] for ADDI, SUBI, CMPI, Bcond.
  - Zero-extend for ANDI, ORI, XORI, ADDUI, MOVI, LUI.
  - Shift-immediate forms: imm = {12'b0, IR[3:0]}.
- Condition table:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N.
  - 1000 FS F; 1001 FC !F; 1010 LO !L&!Z; 1011 HS L|Z.
  - 1100 LT !N&!Z; 1101 GE N|Z; 1110 UC 1; 1111 never 0.
- Timing and enables:
  - Conditions are evaluated against the PSR value before any write in the same cycle.
  - Every enable is a single-cycle pulse.
  - Outputs are combinational from state + IR; IR and PSR are registered.

Decomposition:
- Package cr16_pkg holds:
  - opcode/ext constants shared with the ALU;
  - state encoding (FETCH = 0, DECODE = 1, EXEC = 2, MEM_RD = 3);
  - condition-code constants;
  - rf_wsel and pc_src encodings.
- Sub-module cond_eval: combinational (cond[3:0], psr[4:0]) -> take.

Test Plan:
- Reset, then ADD R3,R4 (16'h0354) in mem_rdata -> states 0,1,2,0; EXEC: alu_op = 8'h05, rf_we = 1, alu_src_imm = 0, pc_en = 1 for exactly 1 cycle.
- ADDI R1,#-2 (16'h51FE) -> imm_out = 16'hFFFE, alu_src_imm = 1; ORI R1,#8'h80 -> imm_out = 16'h0080.
- LOAD R2,[R5] (16'h4205) -> FETCH, DECODE, EXEC with mem_addr_sel = 1, MEM_RD with rf_we = 1 and rf_wsel = 1; 4 cycles total.
- PSR Z = 1 via CMP with ALU Z = 1; BEQ (16'hC0FC) -> pc_src = 1, imm_out = 16'hFFFC; with Z = 0 -> pc_src = 0; never (16'hCF00) -> pc_src = 0.
- JAL R14,R7 (16'h4E87) -> rf_we = 1, rf_wsel = 2, rf_waddr = 14, pc_src = 2 in EXEC.
- reset_n low during MEM_RD -> next state FETCH, rf_we = 0, PSR = 0, IR = 0.
